nibble_parity_tx: RTL

//   Downstream stage of the 4-bit odd-parity generator. Accepts one nibble per

---
 rtl/nibble_parity_tx_if.sv | 20 ++
 rtl/nibble_parity_tx.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/nibble_parity_tx_if.sv
// Upstream valid/ready handshake carrying one data word per transfer.
interface nibble_parity_tx_if #(
    parameter int DATA_W = 4
) ();
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/nibble_parity_tx.sv
// Odd-parity serial framer: accepts one word per handshake and sends
// start(0), data MSB first, odd parity, stop(1); each bit lasts BIT_CYCLES clocks.
module nibble_parity_tx #(
    parameter int DATA_W     = 4,
    parameter int BIT_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    nibble_parity_tx_if.slave   up,
    output logic                tx,
    output logic                busy,
    output logic                frame_done
);
    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cyc_q, cyc_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] shift_nxt;
    logic              par_q, par_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              xfer;
    logic              cyc_wrap;

    // Ready only while idle and not being reset, so rst always wins over in_valid.
    assign up.in_ready = (state_q == IDLE) & ~rst;
    assign xfer        = up.in_valid & up.in_ready;
    assign cyc_wrap    = (cyc_q == CYC_LAST);
    assign shift_nxt   = shift_q << 1;

    assign tx          = tx_q;
    assign busy        = busy_q;
    assign frame_done  = done_q;

    // Next-state logic; tx is computed for the state being entered so the
    // registered output carries no extra latency.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        if (state_q != IDLE) begin
            cyc_d = cyc_wrap ? '0 : cyc_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (xfer) begin
                    state_d = START;
                    shift_d = up.in_data;
                    par_d   = ~^up.in_data;
                    cyc_d   = '0;
                    bit_d   = '0;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            START: begin
                if (cyc_wrap) begin
                    state_d = DATA;
                    bit_d   = '0;
                    tx_d    = shift_q[DATA_W-1];
                end
            end
            DATA: begin
                if (cyc_wrap) begin
                    if (bit_q == BIT_LAST) begin
                        state_d = PARITY;
                        tx_d    = par_q;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_nxt;
                        tx_d    = shift_nxt[DATA_W-1];
                    end
                end
            end
            PARITY: begin
                if (cyc_wrap) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
            STOP: begin
                if (cyc_wrap) begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any frame and idles the line high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end
endmodule
